memory_sequencer: RTL and testbench

//  Parametrised access sequencer around an internal single-port, write-first RAM.

---
 rtl/memory_sequencer.sv | 152 +++++++++++++++
 tb/tb_memory_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_sequencer.sv
// Phased access sequencer around an internal single-port, write-first RAM.
// Optional burst support (burst_length/data_take ports) is built when MEMSEQ_BURST_EN is defined.
module memory_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0,
  parameter int BURST_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  request,
  input  logic                  write_mode,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
`ifdef MEMSEQ_BURST_EN
  input  logic [BURST_WIDTH-1:0] burst_length,
  output logic                   data_take,
`endif
  output logic [DATA_WIDTH-1:0] buffer,
  output logic                  ready,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT,
    S_CAPTURE
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    write_reg;
  logic [3:0]              wait_count;
  logic                    ram_en;
  logic                    ram_we;
  logic [DATA_WIDTH-1:0]   ram_dout;
  logic [DATA_WIDTH-1:0]   mem [0:(2**ADDR_WIDTH)-1];
`ifdef MEMSEQ_BURST_EN
  logic [BURST_WIDTH-1:0]  count;
  logic                    first_word;
`endif

  // Write-first RAM: on a write the output register takes the new word.
  always_ff @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[addr_reg] <= data_reg;
        ram_dout      <= data_reg;
      end else begin
        ram_dout <= mem[addr_reg];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_reg   <= '0;
      data_reg   <= '0;
      write_reg  <= 1'b0;
      wait_count <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      buffer     <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
`ifdef MEMSEQ_BURST_EN
      count      <= '0;
      first_word <= 1'b0;
      data_take  <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
`ifdef MEMSEQ_BURST_EN
      data_take <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          if (request) begin
            addr_reg  <= address;
            data_reg  <= data;
            write_reg <= write_mode;
            ram_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= S_SETUP;
`ifdef MEMSEQ_BURST_EN
            count      <= burst_length;
            first_word <= 1'b1;
            data_take  <= write_mode;
`endif
          end
        end
        S_SETUP: begin
`ifdef MEMSEQ_BURST_EN
          // Later burst words pick up fresh write data while data_take is high.
          if (write_reg && !first_word) data_reg <= data;
          first_word <= 1'b0;
`endif
          ram_we <= write_reg;
          state  <= S_ACCESS;
        end
        S_ACCESS: begin
          ram_we <= 1'b0;
          if (WAIT_CYCLES == 0) begin
            state <= S_CAPTURE;
          end else begin
            wait_count <= WAIT_LOAD;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_count == 4'd0) state <= S_CAPTURE;
          else wait_count <= 4'(wait_count - 4'd1);
        end
        S_CAPTURE: begin
          buffer <= ram_dout;
          ready  <= 1'b1;
`ifdef MEMSEQ_BURST_EN
          if (count != '0) begin
            count     <= BURST_WIDTH'(count - 1);
            addr_reg  <= ADDR_WIDTH'(addr_reg + 1);
            data_take <= write_reg;
            state     <= S_SETUP;
          end else begin
            ram_en <= 1'b0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
`else
          ram_en <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
`endif
        end
        default: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_sequencer.sv
// Randomized self-checking bench for memory_sequencer: two instances (WAIT_CYCLES 0 and 2)
// share one request stream and are compared against a word-array model of the RAM.
module tb_memory_sequencer;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          request;
  logic          write_mode;
  logic [AW-1:0] address;
  logic [DW-1:0] data_i [2];
  logic [DW-1:0] buffer_o [2];
  logic [1:0]    ready_o;
  logic [1:0]    busy_o;
  logic [1:0]    take_o;
  logic [3:0]    burst_length;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] model [1024];
  int            knownList[$];
  logic [DW-1:0] words [16];

  always #5 clock = ~clock;

  memory_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(0), .BURST_WIDTH(4)) dut0 (
    .clock(clock), .reset_n(reset_n), .request(request), .write_mode(write_mode),
    .address(address), .data(data_i[0]),
`ifdef MEMSEQ_BURST_EN
    .burst_length(burst_length), .data_take(take_o[0]),
`endif
    .buffer(buffer_o[0]), .ready(ready_o[0]), .busy(busy_o[0])
  );

  memory_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(2), .BURST_WIDTH(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .request(request), .write_mode(write_mode),
    .address(address), .data(data_i[1]),
`ifdef MEMSEQ_BURST_EN
    .burst_length(burst_length), .data_take(take_o[1]),
`endif
    .buffer(buffer_o[1]), .ready(ready_o[1]), .busy(busy_o[1])
  );

`ifndef MEMSEQ_BURST_EN
  assign take_o = 2'b00;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One handshake of nwords words; optionally pokes an ignored write to 0x3FF while busy.
  task automatic applyStimulus(input bit we, input logic [AW-1:0] addr, input int nwords, input bit poke);
    int            lat[2];
    int            nready[2];
    int            ntake[2];
    logic [DW-1:0] expv[$];
    logic [AW-1:0] a;
    for (int i = 0; i < nwords; i++) begin
      a = AW'(addr + i);
      if (we) begin
        model[a] = words[i];
        knownList.push_back(int'(a));
      end
      expv.push_back(model[a]);
    end
    @(negedge clock);
    request      = 1'b1;
    write_mode   = we;
    address      = addr;
    data_i[0]    = words[0];
    data_i[1]    = words[0];
    burst_length = 4'(nwords - 1);
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      lat[d] = -1;
      nready[d] = 0;
      ntake[d] = 0;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k == 0) begin
        request      = 1'b0;
        write_mode   = 1'($urandom);
        address      = AW'($urandom);
        burst_length = 4'($urandom);
        data_i[0]    = DW'($urandom);
        data_i[1]    = DW'($urandom);
        checkOutput("busy_w0", 32'(busy_o[0]), 32'd1);
        checkOutput("busy_w2", 32'(busy_o[1]), 32'd1);
      end
      if (poke && k == 1) begin
        request    = 1'b1;
        write_mode = 1'b1;
        address    = 10'h3FF;
        data_i[0]  = 16'hFFFF;
        data_i[1]  = 16'hFFFF;
      end
      if (poke && k == 2) request = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (ready_o[d]) begin
          if (nready[d] == 0) lat[d] = k;
          if (nready[d] < nwords)
            checkOutput(d == 0 ? "buffer_w0" : "buffer_w2", 32'(buffer_o[d]), 32'(expv[nready[d]]));
          nready[d]++;
        end
        if (take_o[d]) begin
          if (ntake[d] < nwords) data_i[d] = words[ntake[d]];
          ntake[d]++;
        end
      end
      if (nready[0] >= nwords && nready[1] >= nwords && busy_o == 2'b00) break;
    end
    checkOutput("latency_w0", 32'(lat[0]), 32'd3);
    checkOutput("latency_w2", 32'(lat[1]), 32'd5);
    checkOutput("ready_count_w0", 32'(nready[0]), 32'(nwords));
    checkOutput("ready_count_w2", 32'(nready[1]), 32'(nwords));
`ifdef MEMSEQ_BURST_EN
    checkOutput("take_count_w0", 32'(ntake[0]), we ? 32'(nwords) : 32'd0);
    checkOutput("take_count_w2", 32'(ntake[1]), we ? 32'(nwords) : 32'd0);
`endif
  endtask

  initial begin
    int maxWords;
    reset_n      = 1'b0;
    request      = 1'b1;
    write_mode   = 1'b1;
    address      = '0;
    data_i[0]    = 16'hFFFF;
    data_i[1]    = 16'hFFFF;
    burst_length = 4'hF;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_buffer", 32'(buffer_o[d]), 32'd0);
      checkOutput("reset_ready", 32'(ready_o[d]), 32'd0);
      checkOutput("reset_busy", 32'(busy_o[d]), 32'd0);
    end
    request = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    words[0] = 16'hA5C3;
    applyStimulus(1'b1, 10'h155, 1, 1'b0);
    applyStimulus(1'b0, 10'h155, 1, 1'b0);
    words[0] = 16'h1234;
    applyStimulus(1'b1, 10'h0AA, 1, 1'b0);
    applyStimulus(1'b0, 10'h0AA, 1, 1'b0);

    words[0] = 16'h5A5A;
    applyStimulus(1'b1, 10'h3FF, 1, 1'b0);
    applyStimulus(1'b0, 10'h155, 1, 1'b1);
    applyStimulus(1'b0, 10'h3FF, 1, 1'b0);

    words[0] = 16'h0F0F;
    applyStimulus(1'b1, 10'h010, 1, 1'b0);
    @(negedge clock);
    request    = 1'b1;
    write_mode = 1'b1;
    address    = 10'h010;
    data_i[0]  = 16'hBEEF;
    data_i[1]  = 16'hBEEF;
    @(posedge clock);
    @(negedge clock);
    request = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(ready_o), 32'd0);
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      checkOutput("after_abort_ready", 32'(ready_o), 32'd0);
      checkOutput("after_abort_busy", 32'(busy_o), 32'd0);
    end
    applyStimulus(1'b0, 10'h010, 1, 1'b0);

`ifdef MEMSEQ_BURST_EN
    maxWords = 4;
    for (int i = 0; i < 4; i++) words[i] = 16'(i + 1);
    applyStimulus(1'b1, 10'h3FE, 4, 1'b0);
    applyStimulus(1'b0, 10'h3FE, 1, 1'b0);
    applyStimulus(1'b0, 10'h3FF, 1, 1'b0);
    applyStimulus(1'b0, 10'h000, 1, 1'b0);
    applyStimulus(1'b0, 10'h001, 1, 1'b0);
    applyStimulus(1'b0, 10'h3FE, 4, 1'b0);
`else
    maxWords = 1;
`endif

    for (int n = 0; n < 30; n++) begin
      int nw;
      nw = 1 + int'($urandom_range(maxWords - 1));
      if (knownList.size() == 0 || ($urandom % 2) == 0) begin
        for (int i = 0; i < nw; i++) words[i] = DW'($urandom);
        applyStimulus(1'b1, AW'($urandom), nw, 1'b0);
      end else begin
        applyStimulus(1'b0, AW'(knownList[$urandom_range(knownList.size() - 1)]), 1, ($urandom % 4) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
